alu_unit: RTL and testbench

//  Handshaked execute unit that consumes the 3-bit ALUControl code produced by aludec
//  and returns a registered result plus a zero flag.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_if.sv | 23 ++
 rtl/alu_shifter_iter.sv | 59 +++++
 rtl/alu_unit.sv | 113 +++++++++++
 tb/tb_alu_unit.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU op codes and FSM state encodings
package alu_pkg;

  // Codes 000..011 and 101 match the aludec encoding; 100/110/111 are the shift extension.
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLL = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SRL = 3'b110;
  localparam logic [2:0] ALU_SRA = 3'b111;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } alu_state_e;

  function automatic logic is_shift_op(input logic [2:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_if.sv
// rtl/alu_if.sv - request/response handshake bundle of the ALU execute unit
interface alu_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       alu_control;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             busy;

  modport master (
    output in_valid, alu_control, src_a, src_b, out_ready,
    input  in_ready, out_valid, result, zero, busy
  );

  modport slave (
    input  in_valid, alu_control, src_a, src_b, out_ready,
    output in_ready, out_valid, result, zero, busy
  );
endinterface

// File: rtl/alu_shifter_iter.sv
// rtl/alu_shifter_iter.sv - one-bit-per-cycle shifter holding work value, count and op
module alu_shifter_iter
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_i,
  input  logic               step_i,
  input  logic [2:0]         op_i,
  input  logic [WIDTH-1:0]   data_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  output logic [WIDTH-1:0]   shift_o,
  output logic               last_o
);

  logic [WIDTH-1:0]   work_q, work_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [2:0]         op_q, op_d;

  always_comb begin
    unique case (op_q)
      ALU_SLL: shift_o = {work_q[WIDTH-2:0], 1'b0};
      ALU_SRL: shift_o = {1'b0, work_q[WIDTH-1:1]};
      default: shift_o = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
    endcase
  end

  assign last_o = (cnt_q == SHAMT_W'(1));

  always_comb begin
    work_d = work_q;
    cnt_d  = cnt_q;
    op_d   = op_q;
    if (start_i) begin
      work_d = data_i;
      cnt_d  = shamt_i;
      op_d   = op_i;
    end else if (step_i) begin
      work_d = shift_o;
      cnt_d  = cnt_q - SHAMT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      work_q <= '0;
      cnt_q  <= '0;
      op_q   <= ALU_SLL;
    end else begin
      work_q <= work_d;
      cnt_q  <= cnt_d;
      op_q   <= op_d;
    end
  end

endmodule

// File: rtl/alu_unit.sv
// rtl/alu_unit.sv - handshaked ALU: single-cycle arithmetic/logic, iterative shifts
module alu_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic clk,
  input  logic reset,
  alu_if.slave bus
);

  localparam int SHAMT_W = $clog2(WIDTH);

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready;
  logic             accept;
  logic             shift_start;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] shift_val;
  logic             shift_last;
  logic [SHAMT_W-1:0] shamt;

  assign shamt = bus.src_b[SHAMT_W-1:0];

  // Shift codes land here only when shamt is zero, so passing src_a through is correct.
  always_comb begin
    unique case (bus.alu_control)
      ALU_ADD: alu_res = bus.src_a + bus.src_b;
      ALU_SUB: alu_res = bus.src_a - bus.src_b;
      ALU_AND: alu_res = bus.src_a & bus.src_b;
      ALU_OR:  alu_res = bus.src_a | bus.src_b;
      ALU_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.src_a) < $signed(bus.src_b))};
      default: alu_res = bus.src_a;
    endcase
  end

  alu_shifter_iter #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) u_shifter (
    .clk     (clk),
    .reset   (reset),
    .start_i (shift_start),
    .step_i  (state_q == SHIFT),
    .op_i    (bus.alu_control),
    .data_i  (bus.src_a),
    .shamt_i (shamt),
    .shift_o (shift_val),
    .last_o  (shift_last)
  );

  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    zero_d      = zero_q;
    out_valid_d = out_valid_q;
    shift_start = 1'b0;
    in_ready    = !reset && (state_q == IDLE) && (!out_valid_q || bus.out_ready);
    accept      = bus.in_valid && in_ready;

    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_shift_op(bus.alu_control) && (shamt != '0)) begin
            shift_start = 1'b1;
            state_d     = SHIFT;
          end else begin
            result_d    = alu_res;
            zero_d      = (alu_res == '0);
            out_valid_d = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (shift_last) begin
          result_d    = shift_val;
          zero_d      = (shift_val == '0);
          out_valid_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      result_q    <= '0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.busy      = (state_q == SHIFT);

endmodule

// File: tb/tb_alu_unit.sv
// tb/tb_alu_unit.sv - scoreboard testbench for alu_unit
module tb_alu_unit;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  logic [32:0] exp_q[$];

  always #5 clk = ~clk;

  alu_if #(.WIDTH(32)) bus ();

  alu_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every output transfer must match the oldest expected response.
  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_output: got result=0x%08h zero=%0b expected no output",
                 bus.result, bus.zero);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        if ({bus.result, bus.zero} !== e) begin
          failures++;
          $display("FAIL scoreboard: got result=0x%08h zero=%0b expected result=0x%08h zero=%0b",
                   bus.result, bus.zero, e[32:1], e[0]);
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accept edge.
  task automatic issue(input logic [2:0] ctl, input logic [31:0] a, input logic [31:0] b,
                       input logic push, input logic [31:0] exp_r, input logic exp_z,
                       output int waits);
    bus.in_valid    = 1'b1;
    bus.alu_control = ctl;
    bus.src_a       = a;
    bus.src_b       = b;
    waits = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      waits++;
      if (waits > 100) begin
        checks++;
        failures++;
        $display("FAIL accept_timeout: got in_ready=0 expected 1 within 100 cycles");
        break;
      end
      @(posedge clk);
      #1;
    end
    if (push && bus.in_ready) exp_q.push_back({exp_r, exp_z});
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    int w;
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.alu_control = ALU_ADD;
    bus.src_a = '0;
    bus.src_b = '0;
    bus.out_ready = 1'b1;
    cycle();
    cycle();
    chk("reset_in_ready", 32'(bus.in_ready), 0);
    chk("reset_out_valid", 32'(bus.out_valid), 0);
    chk("reset_result", bus.result, 0);
    chk("reset_zero", 32'(bus.zero), 0);
    chk("reset_busy", 32'(bus.busy), 0);
    reset = 1'b0;
    #1;
    chk("ready_after_reset", 32'(bus.in_ready), 1);
    cycle();

    issue(ALU_ADD, 5, 7, 1, 12, 0, w);
    chk("add_latency_valid", 32'(bus.out_valid), 1);
    chk("add_latency_result", bus.result, 12);
    issue(ALU_SUB, 3, 3, 1, 0, 1, w);
    issue(ALU_SUB, 0, 1, 1, 32'hFFFF_FFFF, 0, w);
    issue(ALU_AND, 32'hF0F0, 32'hFF00, 1, 32'hF000, 0, w);
    issue(ALU_OR,  32'hF0F0, 32'hFF00, 1, 32'hFFF0, 0, w);
    issue(ALU_SLT, 32'hFFFF_FFFF, 1, 1, 1, 0, w);
    issue(ALU_SLT, 1, 32'hFFFF_FFFF, 1, 0, 1, w);
    issue(ALU_SLT, 4, 4, 1, 0, 1, w);

    issue(ALU_SRA, 32'h8000_0000, 4, 1, 32'hF800_0000, 0, w);
    for (int i = 0; i < 4; i++) begin
      chk("sra_busy", 32'(bus.busy), 1);
      chk("sra_in_ready", 32'(bus.in_ready), 0);
      chk("sra_out_valid", 32'(bus.out_valid), 0);
      cycle();
    end
    chk("sra_done_busy", 32'(bus.busy), 0);
    chk("sra_done_valid", 32'(bus.out_valid), 1);
    issue(ALU_SRL, 32'h8000_0000, 4, 1, 32'h0800_0000, 0, w);
    issue(ALU_SLL, 1, 31, 1, 32'h8000_0000, 0, w);
    issue(ALU_SLL, 32'h1234, 32'h20, 1, 32'h1234, 0, w);
    chk("sll0_valid", 32'(bus.out_valid), 1);
    chk("sll0_result", bus.result, 32'h1234);
    chk("sll0_busy", 32'(bus.busy), 0);
    cycle();
    cycle();

    bus.out_ready = 1'b0;
    issue(ALU_ADD, 1, 1, 1, 2, 0, w);
    bus.in_valid = 1'b1;
    bus.alu_control = ALU_ADD;
    bus.src_a = 10;
    bus.src_b = 20;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_result", bus.result, 2);
      chk("hold_valid", 32'(bus.out_valid), 1);
      chk("hold_in_ready", 32'(bus.in_ready), 0);
      cycle();
    end
    bus.out_ready = 1'b1;
    issue(ALU_ADD, 10, 20, 1, 30, 0, w);
    chk("drain_accept_waits", w, 0);
    issue(ALU_SUB, 50, 8, 1, 42, 0, w);
    chk("b2b_waits_1", w, 0);
    issue(ALU_OR, 1, 2, 1, 3, 0, w);
    chk("b2b_waits_2", w, 0);
    issue(ALU_AND, 6, 3, 1, 2, 0, w);
    chk("b2b_waits_3", w, 0);
    cycle();

    issue(ALU_SRA, 32'h8000_0000, 8, 0, 0, 0, w);
    cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    #1;
    chk("abort_out_valid", 32'(bus.out_valid), 0);
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_in_ready", 32'(bus.in_ready), 1);
    chk("abort_result", bus.result, 0);
    for (int i = 0; i < 12; i++) begin
      cycle();
      chk("no_stale_valid", 32'(bus.out_valid), 0);
    end

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
